mod_counter_chain: RTL and testbench

- Parametrised cascade of STAGES synchronous modulo counters, e.g. seconds/minutes/hours, with up/down counting and per-stage wrap strobes.
- Runtime per-stage preset through a valid/ready load port.
- Next-generation time-base block for the clock designs; replaces hand-chained single-stage counters with one block and one common tick.

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_stage.sv | 62 ++++++
 rtl/mod_counter_chain.sv | 122 ++++++++++++
 tb/tb_mod_counter_chain.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types, defaults and helpers for the cascaded modulo counter chain.
package counter_pkg;

    typedef enum logic {IDLE, APPLY} load_state_t;

    localparam int unsigned DEFAULT_STAGES = 3;
    localparam int DEFAULT_LIMITS [DEFAULT_STAGES] = '{60, 60, 24};

    function automatic logic [7:0] bin2bcd8(input int unsigned bin);
        return {4'(bin / 10), 4'(bin % 10)};
    endfunction

    function automatic logic in_range(input int unsigned value, input int unsigned limit);
        return value < limit;
    endfunction

endpackage

// File: rtl/counter_stage.sv
// One mod-LIMIT up/down counter stage with synchronous load and wrap strobe.
// MOD_COUNTER_CHAIN_BCD_EN adds a registered two-digit BCD copy of the value.
module counter_stage
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned LIMIT = 60
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iDown,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iLoadData,
`ifdef MOD_COUNTER_CHAIN_BCD_EN
    output logic [7:0]       oBcd,
`endif
    output logic [WIDTH-1:0] oValue,
    output logic             oTerm_c,
    output logic             oStrb
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] nextValue;

    // Terminal value depends on the direction presented this cycle.
    always_comb begin
        oTerm_c   = iDown ? (oValue == '0) : (oValue == TOP);
        nextValue = oValue;
        if (iLoad) begin
            nextValue = iLoadData;
        end else if (iEn) begin
            if (oTerm_c) begin
                nextValue = iDown ? TOP : '0;
            end else begin
                nextValue = iDown ? oValue - WIDTH'(1) : oValue + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oValue <= '0;
            oStrb  <= 1'b0;
        end else begin
            oValue <= nextValue;
            oStrb  <= iEn && !iLoad && oTerm_c;
        end
    end

`ifdef MOD_COUNTER_CHAIN_BCD_EN
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oBcd <= '0;
        end else begin
            oBcd <= bin2bcd8(32'(nextValue));
        end
    end
`endif

endmodule

// File: rtl/mod_counter_chain.sv
// Cascade of modulo up/down counters sharing one tick, with a valid/ready preset port.
// Optional MOD_COUNTER_CHAIN_BCD_EN adds the oBcd output.
module mod_counter_chain
    import counter_pkg::*;
#(
    parameter int unsigned STAGES = DEFAULT_STAGES,
    parameter int unsigned WIDTH  = 7,
    parameter int          LIMITS [STAGES] = DEFAULT_LIMITS,
    localparam int unsigned SEL_W = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iEn,
    input  logic                    iDown,
    input  logic                    iLoadValid,
    input  logic [SEL_W-1:0]        iLoadStage,
    input  logic [WIDTH-1:0]        iLoadData,
    output logic                    oLoadReady,
    output logic                    oLoadErr,
    output logic [STAGES-1:0]       oStrb,
    output logic                    oCarry,
`ifdef MOD_COUNTER_CHAIN_BCD_EN
    output logic [STAGES*8-1:0]     oBcd,
`endif
    output logic [STAGES*WIDTH-1:0] oValue
);

    load_state_t      state;
    logic [SEL_W-1:0] ldStage;
    logic [WIDTH-1:0] ldData;
    logic             pendValid;
    logic             pendDown;

    logic              tickEff_c;
    logic              dirEff_c;
    logic              loadErr_c;
    logic [STAGES-1:0] loadSel_c;
    logic [STAGES-1:0] dataBad_c;
    logic [STAGES-1:0] term_c;
    logic [STAGES:0]   cascade_c;

    // A tick held over from APPLY takes priority and merges with any new tick.
    assign tickEff_c    = (state == IDLE) && (iEn || pendValid);
    assign dirEff_c     = pendValid ? pendDown : iDown;
    assign cascade_c[0] = tickEff_c;
    assign loadErr_c    = ~|loadSel_c || |(loadSel_c & dataBad_c);

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:0] loadVal_c;

        if (LIMITS[i] < 2 || LIMITS[i] > 2 ** WIDTH) begin : g_bad_limit
            $error("mod_counter_chain: LIMITS[%0d] out of range", i);
        end
`ifdef MOD_COUNTER_CHAIN_BCD_EN
        if (LIMITS[i] > 100) begin : g_bad_bcd
            $error("mod_counter_chain: LIMITS[%0d] too large for BCD", i);
        end
`endif

        assign loadSel_c[i]   = (ldStage == SEL_W'(i));
        assign dataBad_c[i]   = !in_range(32'(ldData), 32'(LIMITS[i]));
        assign loadVal_c      = dataBad_c[i] ? WIDTH'(LIMITS[i] - 1) : ldData;
        assign cascade_c[i+1] = cascade_c[i] & term_c[i];

        counter_stage #(
            .WIDTH (WIDTH),
            .LIMIT (LIMITS[i])
        ) u_stage (
            .iClk      (iClk),
            .iRst      (iRst),
            .iEn       (cascade_c[i]),
            .iDown     (dirEff_c),
            .iLoad     ((state == APPLY) && loadSel_c[i]),
            .iLoadData (loadVal_c),
`ifdef MOD_COUNTER_CHAIN_BCD_EN
            .oBcd      (oBcd[i*8 +: 8]),
`endif
            .oValue    (oValue[i*WIDTH +: WIDTH]),
            .oTerm_c   (term_c[i]),
            .oStrb     (oStrb[i])
        );
    end

    // Load FSM, pending tick and carry; ticks and load writes never share an edge.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state      <= IDLE;
            ldStage    <= '0;
            ldData     <= '0;
            pendValid  <= 1'b0;
            pendDown   <= 1'b0;
            oLoadReady <= 1'b1;
            oLoadErr   <= 1'b0;
            oCarry     <= 1'b0;
        end else begin
            oLoadErr <= 1'b0;
            oCarry   <= cascade_c[STAGES];
            case (state)
                IDLE: begin
                    pendValid <= 1'b0;
                    if (iLoadValid) begin
                        ldStage    <= iLoadStage;
                        ldData     <= iLoadData;
                        oLoadReady <= 1'b0;
                        state      <= APPLY;
                    end
                end
                APPLY: begin
                    oLoadReady <= 1'b1;
                    oLoadErr   <= loadErr_c;
                    state      <= IDLE;
                    if (iEn) begin
                        pendValid <= 1'b1;
                        pendDown  <= iDown;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_counter_chain.sv
// Directed bench for mod_counter_chain: tick loop, vector table, reset during APPLY.
module tb_mod_counter_chain;

    logic        iClk;
    logic        iRst;
    logic        iEn;
    logic        iDown;
    logic        iLoadValid;
    logic [1:0]  iLoadStage;
    logic [6:0]  iLoadData;
    logic        oLoadReady;
    logic        oLoadErr;
    logic [2:0]  oStrb;
    logic        oCarry;
    logic [20:0] oValue;
`ifdef MOD_COUNTER_CHAIN_BCD_EN
    logic [23:0] oBcd;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        en;
        logic        down;
        logic        lv;
        logic [1:0]  ls;
        logic [6:0]  ld;
        logic [20:0] expV;
        logic [2:0]  expS;
        logic        expR;
        logic        expE;
    } vec_t;

    vec_t vecs[$];

    mod_counter_chain dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iEn        (iEn),
        .iDown      (iDown),
        .iLoadValid (iLoadValid),
        .iLoadStage (iLoadStage),
        .iLoadData  (iLoadData),
        .oLoadReady (oLoadReady),
        .oLoadErr   (oLoadErr),
        .oStrb      (oStrb),
        .oCarry     (oCarry),
`ifdef MOD_COUNTER_CHAIN_BCD_EN
        .oBcd       (oBcd),
`endif
        .oValue     (oValue)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    function automatic logic [20:0] pv(input int h, input int m, input int s);
        return {7'(h), 7'(m), 7'(s)};
    endfunction

    function automatic vec_t mk(input logic en, input logic down, input logic lv,
                                input int ls, input int ld, input int h, input int m,
                                input int s, input int strb, input logic rdy, input logic err);
        vec_t v;
        v.en = en; v.down = down; v.lv = lv;
        v.ls = 2'(ls); v.ld = 7'(ld);
        v.expV = pv(h, m, s); v.expS = 3'(strb);
        v.expR = rdy; v.expE = err;
        return v;
    endfunction

`ifdef MOD_COUNTER_CHAIN_BCD_EN
    function automatic logic [23:0] bcdOf(input logic [20:0] v);
        logic [23:0] r;
        for (int k = 0; k < 3; k++) begin
            int x;
            x = int'(v[k*7 +: 7]);
            r[k*8 +: 8] = {4'(x / 10), 4'(x % 10)};
        end
        return r;
    endfunction
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic down, input logic lv,
                         input logic [1:0] ls, input logic [6:0] ld);
        iEn = en; iDown = down; iLoadValid = lv; iLoadStage = ls; iLoadData = ld;
        @(posedge iClk);
        #1;
    endtask

    initial begin
        iRst = 1'b0; iEn = 1'b0; iDown = 1'b0;
        iLoadValid = 1'b0; iLoadStage = '0; iLoadData = '0;

        // Vector table: one cycle per row, expectations observed after that edge.
        // Starting state is {h,m,s} = {0,1,1}.
        vecs.push_back(mk(0,0,1,0,59,  0, 1, 1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,  0, 1,59, 0,1,0));
        vecs.push_back(mk(0,0,1,1,59,  0, 1,59, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,  0,59,59, 0,1,0));
        vecs.push_back(mk(0,0,1,2,23,  0,59,59, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0, 23,59,59, 0,1,0));
        vecs.push_back(mk(1,0,0,0, 0,  0, 0, 0, 7,1,0));
        vecs.push_back(mk(0,0,0,0, 0,  0, 0, 0, 0,1,0));
        vecs.push_back(mk(1,1,0,0, 0, 23,59,59, 7,1,0));
        vecs.push_back(mk(0,0,0,0, 0, 23,59,59, 0,1,0));
        vecs.push_back(mk(0,0,1,1,10, 23,59,59, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0, 23,10,59, 0,1,0));
        vecs.push_back(mk(0,0,1,1,75, 23,10,59, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0, 23,59,59, 0,1,1));
        vecs.push_back(mk(0,0,0,0, 0, 23,59,59, 0,1,0));
        vecs.push_back(mk(0,0,1,3, 5, 23,59,59, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0, 23,59,59, 0,1,1));
        vecs.push_back(mk(0,0,0,0, 0, 23,59,59, 0,1,0));
        vecs.push_back(mk(0,0,1,0,58, 23,59,59, 0,0,0));
        vecs.push_back(mk(1,0,0,0, 0, 23,59,58, 0,1,0));
        vecs.push_back(mk(0,0,0,0, 0, 23,59,59, 0,1,0));
        vecs.push_back(mk(0,0,0,0, 0, 23,59,59, 0,1,0));
        vecs.push_back(mk(0,0,1,0,10, 23,59,59, 0,0,0));
        vecs.push_back(mk(1,0,0,0, 0, 23,59,10, 0,1,0));
        vecs.push_back(mk(1,0,0,0, 0, 23,59,11, 0,1,0));
        vecs.push_back(mk(0,0,0,0, 0, 23,59,11, 0,1,0));
        vecs.push_back(mk(0,0,1,0, 0, 23,59,11, 0,0,0));
        vecs.push_back(mk(1,1,0,0, 0, 23,59, 0, 0,1,0));
        vecs.push_back(mk(0,0,0,0, 0, 23,58,59, 1,1,0));
        vecs.push_back(mk(0,0,0,0, 0, 23,58,59, 0,1,0));
        vecs.push_back(mk(1,1,0,0, 0, 23,58,58, 0,1,0));
        vecs.push_back(mk(1,0,0,0, 0, 23,58,59, 0,1,0));
        vecs.push_back(mk(1,0,0,0, 0, 23,59, 0, 1,1,0));

        #12;
        chk("reset_value", 32'(oValue), 32'(0));
        chk("reset_strb",  32'(oStrb),  32'(0));
        chk("reset_carry", 32'(oCarry), 32'(0));
        chk("reset_ready", 32'(oLoadReady), 32'(1));
        chk("reset_err",   32'(oLoadErr), 32'(0));
`ifdef MOD_COUNTER_CHAIN_BCD_EN
        chk("reset_bcd",   32'(oBcd), 32'(0));
`endif
        @(negedge iClk);
        iRst = 1'b1;

        // 59 up ticks: stage0 climbs with no strobe.
        for (int n = 1; n <= 59; n++) begin
            drive(1'b1, 1'b0, 1'b0, 2'd0, 7'd0);
            chk("up_value", 32'(oValue), 32'(pv(0, 0, n)));
            chk("up_strb", 32'(oStrb), 32'(0));
        end
        drive(1'b1, 1'b0, 1'b0, 2'd0, 7'd0);
        chk("wrap60_value", 32'(oValue), 32'(pv(0, 1, 0)));
        chk("wrap60_strb", 32'(oStrb), 32'(1));
        chk("wrap60_carry", 32'(oCarry), 32'(0));
        drive(1'b1, 1'b0, 1'b0, 2'd0, 7'd0);
        chk("held_value", 32'(oValue), 32'(pv(0, 1, 1)));
        chk("held_strb", 32'(oStrb), 32'(0));

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].down, vecs[i].lv, vecs[i].ls, vecs[i].ld);
            chk($sformatf("vec%0d_value", i), 32'(oValue), 32'(vecs[i].expV));
            chk($sformatf("vec%0d_strb", i), 32'(oStrb), 32'(vecs[i].expS));
            chk($sformatf("vec%0d_carry", i), 32'(oCarry), 32'(vecs[i].expS[2]));
            chk($sformatf("vec%0d_ready", i), 32'(oLoadReady), 32'(vecs[i].expR));
            chk($sformatf("vec%0d_err", i), 32'(oLoadErr), 32'(vecs[i].expE));
`ifdef MOD_COUNTER_CHAIN_BCD_EN
            chk($sformatf("vec%0d_bcd", i), 32'(oBcd), 32'(bcdOf(vecs[i].expV)));
`endif
        end

        // Reset during APPLY discards the pending load.
        drive(1'b0, 1'b0, 1'b1, 2'd0, 7'd30);
        chk("rst_apply_ready_low", 32'(oLoadReady), 32'(0));
        iLoadValid = 1'b0;
        #2 iRst = 1'b0;
        #1;
        chk("rst_async_value", 32'(oValue), 32'(0));
        chk("rst_async_ready", 32'(oLoadReady), 32'(1));
        chk("rst_async_strb", 32'(oStrb), 32'(0));
        chk("rst_async_err", 32'(oLoadErr), 32'(0));
        #2 iRst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 7'd0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 7'd0);
        chk("rst_no_load_value", 32'(oValue), 32'(0));
        chk("rst_no_load_ready", 32'(oLoadReady), 32'(1));
        chk("rst_no_load_err", 32'(oLoadErr), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
